output_writeback_scheduler: RTL

OUTPUT_WRITEBACK_SCHEDULER -- requirements
Module: output_writeback_scheduler

---
 rtl/output_writeback_scheduler_if.sv | 49 ++++
 rtl/output_writeback_scheduler.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/output_writeback_scheduler_if.sv
// Handshake and SRAM write-port bundle between the convolution datapath, the
// write-back scheduler and the output SRAM.
interface output_writeback_scheduler_if;
  logic        wb_start;
  logic [11:0] base_addr;
  logic        result_valid;
  logic [15:0] result_data;
  logic        result_last;
  logic        result_ready;
  logic        wb_grant;
  logic [11:0] dut_sram_write_address;
  logic [15:0] dut_sram_write_data;
  logic        dut_sram_write_enable;
  logic        wb_busy;
  logic        wb_done;
  logic [11:0] word_count;

  modport master (
    output wb_start,
    output base_addr,
    output result_valid,
    output result_data,
    output result_last,
    output wb_grant,
    input  result_ready,
    input  dut_sram_write_address,
    input  dut_sram_write_data,
    input  dut_sram_write_enable,
    input  wb_busy,
    input  wb_done,
    input  word_count
  );

  modport slave (
    input  wb_start,
    input  base_addr,
    input  result_valid,
    input  result_data,
    input  result_last,
    input  wb_grant,
    output result_ready,
    output dut_sram_write_address,
    output dut_sram_write_data,
    output dut_sram_write_enable,
    output wb_busy,
    output wb_done,
    output word_count
  );
endinterface

// File: rtl/output_writeback_scheduler.sv
// Buffers convolution results in a 4-deep FIFO and writes them to consecutive
// output SRAM addresses whenever the shared write port is granted.
//
// state | meaning
// IDLE  | waiting for wb_start; base address and counters loaded on start
// RUN   | accepting result words and writing them out
// DRAIN | last word accepted; emptying the FIFO into SRAM
// DONE  | one-cycle completion pulse, then back to IDLE
module output_writeback_scheduler (
  input  logic                         clk,
  input  logic                         reset_b,
  output_writeback_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] fifo_mem [4];
  logic [1:0]  rd_ptr;
  logic [1:0]  wr_ptr;
  logic [2:0]  occupancy;
  logic        fifo_empty;
  logic        fifo_full;

  logic [11:0] write_ptr;
  logic [11:0] wc;
  logic [11:0] addr_q;
  logic [15:0] data_q;
  logic        we_q;

  logic        start_pass;
  logic        ready_int;
  logic        push;
  logic        pop;
  logic        active;

  assign fifo_empty = (occupancy == 3'd0);
  assign fifo_full  = (occupancy == 3'd4);
  assign active     = (state == RUN) || (state == DRAIN);
  assign start_pass = (state == IDLE) && bus.wb_start;

  // Ready depends only on registered state, never on a same-cycle pop.
  assign ready_int  = (state == RUN) && !fifo_full;
  assign push       = ready_int && bus.result_valid;
  assign pop        = active && !fifo_empty && bus.wb_grant;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.wb_start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (push && bus.result_last) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty && !pop) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Storage needs no reset: pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= bus.result_data;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rd_ptr    <= 2'd0;
      wr_ptr    <= 2'd0;
      occupancy <= 3'd0;
    end else if (start_pass) begin
      rd_ptr    <= 2'd0;
      wr_ptr    <= 2'd0;
      occupancy <= 3'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 3'd1;
        2'b01:   occupancy <= occupancy - 3'd1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Write pointer and word count wrap naturally at 12 bits.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      write_ptr <= 12'h000;
      wc        <= 12'h000;
      addr_q    <= 12'h000;
      data_q    <= 16'h0000;
      we_q      <= 1'b0;
    end else begin
      if (start_pass) begin
        write_ptr <= bus.base_addr;
        wc        <= 12'h000;
      end
      if (pop) begin
        we_q      <= 1'b1;
        addr_q    <= write_ptr;
        data_q    <= fifo_mem[rd_ptr];
        write_ptr <= write_ptr + 12'h001;
        wc        <= wc + 12'h001;
      end else begin
        we_q      <= 1'b0;
      end
    end
  end

  assign bus.result_ready           = ready_int;
  assign bus.dut_sram_write_address = addr_q;
  assign bus.dut_sram_write_data    = data_q;
  assign bus.dut_sram_write_enable  = we_q;
  assign bus.wb_busy                = active;
  assign bus.wb_done                = (state == DONE);
  assign bus.word_count             = wc;

endmodule
